// File: rtl/jtkcpu_stack_seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : jtkcpu_stack_seq_pkg
// Brief   : State encoding and register-mask helpers for the stack sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package jtkcpu_stack_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PDEC = 3'd1,
    ST_PWR  = 3'd2,
    ST_RD   = 3'd3,
    ST_FIN  = 3'd4
  } stack_state_t;

  // Mask bits 7..4 are PC, U/S, Y, X: the 16-bit registers
  localparam logic [7:0] C_WIDE_MASK = 8'hF0;

  function automatic logic is_wide(input logic [7:0] bit_oh);
    return |(bit_oh & C_WIDE_MASK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtkcpu_stack_seq.sv
//------------------------------------------------------------------------------
// Module  : jtkcpu_stack_seq
// Brief   : Paces PSHx/PULx/interrupt stack transfers one byte per memory access.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jtkcpu_stack_seq
  import jtkcpu_stack_seq_pkg::*;
(
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       cen2,
  input  logic       start_psh,
  input  logic       start_pul,
  input  logic       ussel_in,
  input  logic [7:0] postbyte,
  input  logic [7:0] stack_bit,
  input  logic       mem_ready,
  output logic [7:0] psh_sel,
  output logic       psh_hihalf,
  output logic       psh_ussel,
  output logic       psh_dec,
  output logic       pul_en,
  output logic       stack_busy,
  output logic       mem_we,
  output logic       mem_rd,
  output logic       done
);

  stack_state_t r_state, w_next;
  logic [7:0]   r_sel, w_sel_nxt, w_remain;
  logic         r_half, w_half_nxt;
  logic         r_ussel, w_ussel_nxt;
  logic         w_wide, w_first_half;
  logic         w_unused;

  assign w_unused     = cen2;
  assign w_remain     = r_sel & ~stack_bit;
  assign w_wide       = is_wide(stack_bit);
  assign w_first_half = w_wide && !r_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 8'd0;
      r_half  <= 1'b0;
      r_ussel <= 1'b0;
    end else if (cen) begin
      r_state <= w_next;
      r_sel   <= w_sel_nxt;
      r_half  <= w_half_nxt;
      r_ussel <= w_ussel_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_sel_nxt   = r_sel;
    w_half_nxt  = r_half;
    w_ussel_nxt = r_ussel;
    case (r_state)
      ST_IDLE: begin
        if (start_psh || start_pul) begin
          if (postbyte == 8'd0) begin
            w_next = ST_FIN;
          end else begin
            w_sel_nxt   = postbyte;
            w_ussel_nxt = ussel_in;
            w_half_nxt  = 1'b0;
            w_next      = start_psh ? ST_PDEC : ST_RD;
          end
        end
      end
      ST_PDEC: w_next = ST_PWR;
      ST_PWR, ST_RD: begin
        if (mem_ready) begin
          if (w_first_half) begin
            // first byte of a 16-bit register: stay on the same mask bit
            w_half_nxt = 1'b1;
            w_next     = (r_state == ST_PWR) ? ST_PDEC : ST_RD;
          end else begin
            w_sel_nxt  = w_remain;
            w_half_nxt = 1'b0;
            if (w_remain == 8'd0)
              w_next = ST_FIN;
            else
              w_next = (r_state == ST_PWR) ? ST_PDEC : ST_RD;
          end
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Push emits low byte first, pull emits high byte first
  assign psh_hihalf = (r_state == ST_RD) ? w_first_half : r_half;
  assign psh_sel    = r_sel;
  assign psh_ussel  = r_ussel;
  assign psh_dec    = (r_state == ST_PDEC);
  assign mem_we     = (r_state == ST_PWR);
  assign mem_rd     = (r_state == ST_RD);
  assign pul_en     = (r_state == ST_RD) && mem_ready;
  assign stack_busy = (r_state == ST_PDEC) || (r_state == ST_PWR) || (r_state == ST_RD);
  assign done       = (r_state == ST_FIN);

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_stack_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_jtkcpu_stack_seq
// Brief   : Self-checking bench for the stack transfer sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jtkcpu_stack_seq;

  logic       rst, clk, cen, cen2, start_psh, start_pul, ussel_in, mem_ready;
  logic [7:0] postbyte, stack_bit, psh_sel;
  logic       psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy, mem_we, mem_rd, done;

  jtkcpu_stack_seq dut (
    .rst(rst), .clk(clk), .cen(cen), .cen2(cen2),
    .start_psh(start_psh), .start_pul(start_pul), .ussel_in(ussel_in),
    .postbyte(postbyte), .stack_bit(stack_bit), .mem_ready(mem_ready),
    .psh_sel(psh_sel), .psh_hihalf(psh_hihalf), .psh_ussel(psh_ussel),
    .psh_dec(psh_dec), .pul_en(pul_en), .stack_busy(stack_busy),
    .mem_we(mem_we), .mem_rd(mem_rd), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file priority encoder: push serves highest bit, pull lowest
  logic tb_push;
  always_comb begin
    stack_bit = 8'd0;
    if (tb_push) begin
      for (int i = 0; i < 8; i++) if (psh_sel[i]) begin stack_bit = 8'd0; stack_bit[i] = 1'b1; end
    end else begin
      for (int i = 7; i >= 0; i--) if (psh_sel[i]) begin stack_bit = 8'd0; stack_bit[i] = 1'b1; end
    end
  end

  typedef struct packed {
    logic       cen, start, ready;
    logic       dec, we, rd, pul, busy, done, hi, us;
    logic [7:0] sel;
  } ent_t;

  ent_t trace[$];
  ent_t cur;
  logic cur_valid = 1'b0;
  int   cur_idx   = 0;
  logic cur_push, cur_both, exp_us;
  logic [7:0] cur_mask;

  int n_tests = 0, n_fail = 0;
  int n_wr, n_dec, n_rd, n_pul, n_busy, n_done, done_idx;
  logic [7:0] wr_log[$];
  logic [8:0] pul_log[$];

  always @(negedge clk) begin
    if (cur_valid) begin
      logic [15:0] act, expv;
      act  = {psh_dec, mem_we, mem_rd, pul_en, stack_busy, done, psh_hihalf, psh_ussel, psh_sel};
      expv = {cur.dec, cur.we, cur.rd, cur.pul, cur.busy, cur.done, cur.hi, cur.us, cur.sel};
      n_tests++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL cycle idx%0d dec/we/rd/pul/busy/done/hi/us/sel got %b required %b",
                 cur_idx, act, expv);
      end
      if (cen) begin
        if (mem_we && mem_ready) begin n_wr++; wr_log.push_back(stack_bit); end
        if (mem_rd && mem_ready) n_rd++;
        if (pul_en) begin n_pul++; pul_log.push_back({stack_bit, psh_hihalf}); end
        if (psh_dec) n_dec++;
        if (stack_busy) n_busy++;
        if (done) begin n_done++; if (done_idx < 0) done_idx = cur_idx; end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_dec = 0; n_rd = 0; n_pul = 0; n_busy = 0; n_done = 0; done_idx = -1;
    wr_log.delete(); pul_log.delete();
  endtask

  function automatic ent_t blank(input logic st);
    ent_t e;
    e = '0; e.cen = 1'b1; e.ready = 1'b1; e.start = st; e.us = exp_us;
    return e;
  endfunction

  task automatic add(input ent_t e, input bit dbl);
    ent_t h;
    if (dbl) begin h = e; h.cen = 1'b0; trace.push_back(h); end
    trace.push_back(e);
  endtask

  // Expected per-cycle trace from the instruction-level byte order
  task automatic build(input bit push, input bit us, input bit both, input bit spam, input bit dbl,
                       input logic [7:0] mask, input int stall_bit, input int stall_n);
    ent_t e;
    logic [7:0] sel;
    int b, halves, ns;
    logic hi;
    trace.delete();
    cur_push = push; cur_both = both; cur_mask = mask; tb_push = push;
    add(blank(1'b1), dbl);
    if (mask != 8'd0) exp_us = us;
    sel = mask;
    for (int k = 0; k < 8; k++) begin
      b = push ? 7 - k : k;
      if (mask[b]) begin
        halves = (b >= 4) ? 2 : 1;
        for (int h = 0; h < halves; h++) begin
          hi = push ? (h == 1) : (halves == 2 && h == 0);
          if (push) begin
            e = blank(spam); e.dec = 1'b1; e.busy = 1'b1; e.sel = sel; e.hi = hi; add(e, dbl);
          end
          ns = (b == stall_bit && h == 0) ? stall_n : 0;
          for (int s = 0; s < ns; s++) begin
            e = blank(spam); e.we = push; e.rd = !push; e.busy = 1'b1; e.sel = sel; e.hi = hi;
            e.ready = 1'b0; add(e, dbl);
          end
          e = blank(spam); e.we = push; e.rd = !push; e.pul = !push; e.busy = 1'b1;
          e.sel = sel; e.hi = hi; add(e, dbl);
        end
        sel[b] = 1'b0;
      end
    end
    e = blank(spam); e.done = 1'b1; add(e, dbl);
    add(blank(1'b0), 1'b0);
  endtask

  task automatic run(input int limit);
    for (int i = 0; i < trace.size() && i < limit; i++) begin
      @(posedge clk); #1;
      cen       = trace[i].cen;
      mem_ready = trace[i].ready;
      start_psh = trace[i].start & (cur_push | cur_both);
      start_pul = trace[i].start & (!cur_push | cur_both);
      postbyte  = (trace[i].start && i <= 1) ? cur_mask : 8'hA5;
      ussel_in  = (trace[i].start && i <= 1) ? exp_us : ~exp_us;
      cur = trace[i]; cur_idx = i; cur_valid = 1'b1;
    end
    @(negedge clk); #1;
    cur_valid = 1'b0; start_psh = 1'b0; start_pul = 1'b0; cen = 1'b1; mem_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; cen2 = 1'b0; start_psh = 1'b0; start_pul = 1'b0;
    ussel_in = 1'b0; postbyte = 8'd0; mem_ready = 1'b1; tb_push = 1'b1; exp_us = 1'b0;
    #22;
    chk("reset_outputs", int'({psh_dec, mem_we, mem_rd, pul_en, stack_busy, done,
                              psh_hihalf, psh_ussel, psh_sel}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // PSHS A,B
    clr(); build(1, 0, 0, 0, 0, 8'h06, -1, 0);
    chk("model_len_0x06", trace.size(), 7);
    run(1000);
    chk("pshs06_writes", n_wr, 2);
    chk("pshs06_decs", n_dec, 2);
    chk("pshs06_done_idx", done_idx, 5);
    chk("pshs06_first_B", (wr_log.size() > 0) ? int'(wr_log[0]) : -1, 8'h04);
    chk("pshs06_second_A", (wr_log.size() > 1) ? int'(wr_log[1]) : -1, 8'h02);

    // PULU CC,PC
    clr(); build(0, 1, 0, 0, 0, 8'h81, -1, 0);
    run(1000);
    chk("pulu81_pul_count", n_pul, 3);
    chk("pulu81_byte0_CC", (pul_log.size() > 0) ? int'(pul_log[0]) : -1, {8'h01, 1'b0});
    chk("pulu81_byte1_PChi", (pul_log.size() > 1) ? int'(pul_log[1]) : -1, {8'h80, 1'b1});
    chk("pulu81_byte2_PClo", (pul_log.size() > 2) ? int'(pul_log[2]) : -1, {8'h80, 1'b0});
    chk("pulu81_ussel", int'(psh_ussel), 1);

    // Full mask push
    clr(); build(1, 0, 0, 0, 0, 8'hFF, -1, 0);
    run(1000);
    chk("push_ff_writes", n_wr, 12);
    chk("push_ff_decs", n_dec, 12);
    chk("push_ff_done_idx", done_idx, 25);

    // Empty mask
    clr(); build(1, 1, 0, 0, 0, 8'h00, -1, 0);
    run(1000);
    chk("empty_mem_access", n_wr + n_rd, 0);
    chk("empty_busy_cycles", n_busy, 0);
    chk("empty_done_idx", done_idx, 1);
    chk("empty_ussel_kept", int'(psh_ussel), 0);

    // Bus wait states on X low byte
    clr(); build(1, 1, 0, 0, 0, 8'h10, 4, 3);
    run(1000);
    chk("stall_writes", n_wr, 2);
    chk("stall_decs", n_dec, 2);

    // Enable gaps every other cycle, and starts re-asserted while busy
    clr(); build(1, 0, 0, 1, 1, 8'h34, -1, 0);
    run(1000);
    chk("cengap_writes", n_wr, 5);
    chk("cengap_done", n_done, 1);

    // Simultaneous starts: push wins
    clr(); build(1, 1, 1, 0, 0, 8'h01, -1, 0);
    run(1000);
    chk("both_writes", n_wr, 1);
    chk("both_reads", n_rd, 0);

    // Full mask pull with waits on Y
    clr(); build(0, 0, 0, 1, 0, 8'hFF, 5, 2);
    run(1000);
    chk("pull_ff_puls", n_pul, 12);

    // Reset during pull of Y
    clr(); build(0, 1, 0, 0, 0, 8'h20, -1, 0);
    run(2);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'({psh_dec, mem_we, mem_rd, pul_en, stack_busy, done,
                                psh_hihalf, psh_ussel, psh_sel}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_us = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_done", n_done + int'(done), 0);

    clr(); build(1, 0, 0, 0, 0, 8'h02, -1, 0);
    run(1000);
    chk("after_rst_writes", n_wr, 1);
    chk("after_rst_done_idx", done_idx, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
